// File: rtl/channel_readout_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// channel_readout_sequencer_pkg
//
// Purpose:
//    Shared definitions for the Channel FPGA readout sequencer: the default
//    channel count, the one-hot FSM encoding with its bit positions, and the
//    layout of the Acquisition Event FIFO word.
//
// Contents:
//    NCHAN                      default number of Channel FPGAs
//    IDLE_BIT .. DONE_BIT       bit position of each state in the one-hot code
//    state_e                    one-hot FSM state type
//    TRIG_NUM_LSB/TRIG_NUM_W    trigger number field of the event word
//    TRIG_TYPE_LSB/TRIG_TYPE_W  trigger type field of the event word
// ---------------------------------------------------------------------------
package channel_readout_sequencer_pkg;

   localparam int NCHAN = 5;

   localparam int IDLE_BIT   = 0;
   localparam int SELECT_BIT = 1;
   localparam int REQ_BIT    = 2;
   localparam int WAIT_BIT   = 3;
   localparam int DONE_BIT   = 4;
   localparam int STATE_W    = 5;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 5'(1 << IDLE_BIT),
      ST_SELECT = 5'(1 << SELECT_BIT),
      ST_REQ    = 5'(1 << REQ_BIT),
      ST_WAIT   = 5'(1 << WAIT_BIT),
      ST_DONE   = 5'(1 << DONE_BIT)
   } state_e;

   localparam int EVT_W         = 32;
   localparam int TRIG_NUM_LSB  = 0;
   localparam int TRIG_NUM_W    = 24;
   localparam int TRIG_TYPE_LSB = 24;
   localparam int TRIG_TYPE_W   = 3;

endpackage

// File: rtl/channel_readout_sequencer_chan_priority_encoder.sv
// ---------------------------------------------------------------------------
// chan_priority_encoder
//
// Purpose:
//    Combinational lowest-set-bit finder. Given the mask of channels still
//    waiting to be read, returns the index of the lowest one so channels are
//    serviced in ascending order.
//
// Ports:
//    mask  in   WIDTH   channels still pending
//    idx   out  IDX_W   index of the lowest set bit (0 when mask is empty)
//    any   out  1       mask has at least one bit set
// ---------------------------------------------------------------------------
module chan_priority_encoder #(
   parameter int WIDTH = 5,
   parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] mask,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan from the top bit down so that the last hit, which wins, is the
   // lowest set bit.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx = IDX_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/channel_readout_sequencer.sv
// ---------------------------------------------------------------------------
// channel_readout_sequencer
//
// Purpose:
//    After an acquisition is stored, pops one event word from the Acquisition
//    Event FIFO, then reads each enabled Channel FPGA in ascending index order,
//    waiting on each one for its done or for a timeout, and finally pulses
//    readout_done back to the acquisition controller.
//
// Ports:
//    clk             in   1      40 MHz TTC clock
//    reset           in   1      synchronous, active-high
//    chan_en         in   NCHAN  channels to read, sampled only at event accept
//    evt_valid       in   1      event FIFO holds a word
//    evt_data        in   32     {5'd0, trig_type[2:0], trig_num[23:0]}
//    evt_ready       out  1      FIFO pop strobe (IDLE & evt_valid)
//    chan_read_req   out  NCHAN  one-cycle readout request to the current channel
//    chan_read_done  in   NCHAN  channel finished sending (level or pulse)
//    readout_done    out  1      one-cycle pulse when the whole event is read
//    cur_trig_num    out  24     trigger number of current / last event
//    cur_trig_type   out  3      trigger type of current / last event
//    timeout_mask    out  NCHAN  channels that timed out in current / last event
//    events_read     out  16     completed event count, wraps
//    state           out  5      one-hot FSM state
// ---------------------------------------------------------------------------
module channel_readout_sequencer
   import channel_readout_sequencer_pkg::*;
#(
   parameter int NCHAN   = channel_readout_sequencer_pkg::NCHAN,
   parameter int TIMEOUT = 40000,
   parameter int TMO_W   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NCHAN-1:0]       chan_en,
   input  logic                   evt_valid,
   input  logic [EVT_W-1:0]       evt_data,
   output logic                   evt_ready,
   output logic [NCHAN-1:0]       chan_read_req,
   input  logic [NCHAN-1:0]       chan_read_done,
   output logic                   readout_done,
   output logic [TRIG_NUM_W-1:0]  cur_trig_num,
   output logic [TRIG_TYPE_W-1:0] cur_trig_type,
   output logic [NCHAN-1:0]       timeout_mask,
   output logic [15:0]            events_read,
   output logic [STATE_W-1:0]     state
);

   localparam int IDX_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

   state_e                 state_q,         state_d;
   logic [NCHAN-1:0]       pending_q,       pending_d;
   logic [IDX_W-1:0]       cur_q,           cur_d;
   logic [TMO_W-1:0]       timer_q,         timer_d;
   logic [NCHAN-1:0]       chan_read_req_q, chan_read_req_d;
   logic                   readout_done_q,  readout_done_d;
   logic [NCHAN-1:0]       timeout_mask_q,  timeout_mask_d;
   logic [TRIG_NUM_W-1:0]  trig_num_q,      trig_num_d;
   logic [TRIG_TYPE_W-1:0] trig_type_q,     trig_type_d;
   logic [15:0]            events_read_q,   events_read_d;

   logic [IDX_W-1:0]       enc_idx;
   logic                   enc_any;
   logic [NCHAN-1:0]       cur_mask;
   logic                   cur_done;
   logic                   cur_expired;
   logic                   unused_evt_bits;

   // The top bits of the event word are reserved and carry nothing.
   assign unused_evt_bits = ^evt_data[EVT_W-1:TRIG_TYPE_LSB+TRIG_TYPE_W];

   // Finds the next channel to read among those still pending.
   chan_priority_encoder #(
      .WIDTH (NCHAN),
      .IDX_W (IDX_W)
   ) u_chan_priority_encoder (
      .mask (pending_q),
      .idx  (enc_idx),
      .any  (enc_any)
   );

   // Decode the current channel into a mask once; the wait test, the pending
   // clear, the timeout flag and the request all use it. The done test looks
   // at the level, so a done already high on WAIT entry counts immediately,
   // and done on any other channel is ignored.
   assign cur_mask    = NCHAN'(1) << cur_q;
   assign cur_done    = |(chan_read_done & cur_mask);
   assign cur_expired = (timer_q == TMO_W'(TIMEOUT - 1));

   // The FIFO may only be popped from IDLE, so a second word cannot be
   // taken until the current event has been fully read out.
   assign evt_ready = (state_q == ST_IDLE) & evt_valid;

   // Next-state and next-output logic for the readout sequence. Every
   // register holds by default; the request and done strobes default low so
   // they last a single cycle.
   always_comb begin
      state_d         = state_q;
      pending_d       = pending_q;
      cur_d           = cur_q;
      timer_d         = timer_q;
      chan_read_req_d = '0;
      readout_done_d  = 1'b0;
      timeout_mask_d  = timeout_mask_q;
      trig_num_d      = trig_num_q;
      trig_type_d     = trig_type_q;
      events_read_d   = events_read_q;

      case (state_q)
         ST_IDLE: begin
            if (evt_valid) begin
               trig_num_d     = evt_data[TRIG_NUM_LSB +: TRIG_NUM_W];
               trig_type_d    = evt_data[TRIG_TYPE_LSB +: TRIG_TYPE_W];
               pending_d      = chan_en;
               timeout_mask_d = '0;
               state_d        = (|chan_en) ? ST_SELECT : ST_DONE;
            end
         end

         ST_SELECT: begin
            cur_d   = enc_idx;
            state_d = enc_any ? ST_REQ : ST_DONE;
         end

         ST_REQ: begin
            chan_read_req_d = cur_mask;
            timer_d         = '0;
            state_d         = ST_WAIT;
         end

         ST_WAIT: begin
            timer_d = timer_q + TMO_W'(1);
            if (cur_done || cur_expired) begin
               pending_d = pending_q & ~cur_mask;
               if (!cur_done) begin
                  timeout_mask_d = timeout_mask_q | cur_mask;
               end
               state_d = (|(pending_q & ~cur_mask)) ? ST_SELECT : ST_DONE;
            end
         end

         ST_DONE: begin
            readout_done_d = 1'b1;
            events_read_d  = events_read_q + 16'd1;
            state_d        = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // All sequencer state lives in this one register block. Reset abandons
   // any event in flight and returns quietly to IDLE without a request or a
   // readout_done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         pending_q       <= '0;
         cur_q           <= '0;
         timer_q         <= '0;
         chan_read_req_q <= '0;
         readout_done_q  <= 1'b0;
         timeout_mask_q  <= '0;
         trig_num_q      <= '0;
         trig_type_q     <= '0;
         events_read_q   <= '0;
      end else begin
         state_q         <= state_d;
         pending_q       <= pending_d;
         cur_q           <= cur_d;
         timer_q         <= timer_d;
         chan_read_req_q <= chan_read_req_d;
         readout_done_q  <= readout_done_d;
         timeout_mask_q  <= timeout_mask_d;
         trig_num_q      <= trig_num_d;
         trig_type_q     <= trig_type_d;
         events_read_q   <= events_read_d;
      end
   end

   assign chan_read_req = chan_read_req_q;
   assign readout_done  = readout_done_q;
   assign cur_trig_num  = trig_num_q;
   assign cur_trig_type = trig_type_q;
   assign timeout_mask  = timeout_mask_q;
   assign events_read   = events_read_q;
   assign state         = state_q;

endmodule

// File: tb/tb_channel_readout_sequencer.sv
// ---------------------------------------------------------------------------
// tb_channel_readout_sequencer
//
// Drives whole events into the sequencer and compares every cycle against a
// schedule computed up front from the readout rules: requests go to enabled
// channels in ascending order, three edges after accept or after the previous
// channel finishes, a channel finishes on its done or after TIMEOUT cycles,
// and readout_done follows the last channel by two edges.
// ---------------------------------------------------------------------------
module tb_channel_readout_sequencer;

   localparam int NCHAN   = 5;
   localparam int TIMEOUT = 16;
   localparam int TMO_W   = 16;
   localparam int NEVER   = 1000;

   logic             clk;
   logic             reset;
   logic [NCHAN-1:0] chan_en;
   logic             evt_valid;
   logic [31:0]      evt_data;
   logic             evt_ready;
   logic [NCHAN-1:0] chan_read_req;
   logic [NCHAN-1:0] chan_read_done;
   logic             readout_done;
   logic [23:0]      cur_trig_num;
   logic [2:0]       cur_trig_type;
   logic [NCHAN-1:0] timeout_mask;
   logic [15:0]      events_read;
   logic [4:0]       state;

   int               checks;
   int               errors;
   logic [15:0]      modelCount;

   // Per-event response plan: cycles from request to done for each channel
   // (NEVER or anything >= TIMEOUT means the channel times out), whether done
   // is held as a level, and what noise appears on channels not being read.
   int               dly [NCHAN];
   bit               levelDone;
   bit               randNoise;
   bit               holdValid;
   logic [NCHAN-1:0] noiseConst;

   channel_readout_sequencer #(
      .NCHAN   (NCHAN),
      .TIMEOUT (TIMEOUT),
      .TMO_W   (TMO_W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .chan_en        (chan_en),
      .evt_valid      (evt_valid),
      .evt_data       (evt_data),
      .evt_ready      (evt_ready),
      .chan_read_req  (chan_read_req),
      .chan_read_done (chan_read_done),
      .readout_done   (readout_done),
      .cur_trig_num   (cur_trig_num),
      .cur_trig_type  (cur_trig_type),
      .timeout_mask   (timeout_mask),
      .events_read    (events_read),
      .state          (state)
   );

   // 40 MHz-style free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Runs one complete event starting with an accept in IDLE and checks
   // every cycle up to and including the readout_done pulse.
   task automatic applyStimulus(input logic [NCHAN-1:0] en, input logic [2:0] ttype, input logic [23:0] tnum);
      int               reqAt [NCHAN];
      int               t;
      int               doneAt;
      logic [NCHAN-1:0] expMask;
      logic [NCHAN-1:0] expReq;
      logic [NCHAN-1:0] drv;

      t       = 0;
      expMask = '0;
      for (int ch = 0; ch < NCHAN; ch++) begin
         reqAt[ch] = -1;
         if (en[ch]) begin
            reqAt[ch] = t + 3;
            if (dly[ch] >= TIMEOUT) begin
               expMask[ch] = 1'b1;
               t = reqAt[ch] + TIMEOUT - 1;
            end else begin
               t = reqAt[ch] + dly[ch];
            end
         end
      end
      doneAt     = t + 2;
      modelCount = modelCount + 16'd1;

      for (int c = 0; c <= doneAt; c++) begin
         @(negedge clk);
         evt_valid = (c == 0) || (holdValid && c < doneAt);
         evt_data  = (c == 0) ? {5'd0, ttype, tnum} : $urandom;
         chan_en   = (c == 0) ? en : NCHAN'($urandom);
         drv       = '0;
         for (int ch = 0; ch < NCHAN; ch++) begin
            if (en[ch] && dly[ch] < TIMEOUT) begin
               if (levelDone ? (c >= reqAt[ch] + dly[ch]) : (c == reqAt[ch] + dly[ch])) begin
                  drv[ch] = 1'b1;
               end
            end
         end
         drv = drv | ((noiseConst | (randNoise ? NCHAN'($urandom) : '0)) & ~en);
         chan_read_done = drv;
         #1;
         expReq = '0;
         for (int ch = 0; ch < NCHAN; ch++) begin
            if (reqAt[ch] == c) expReq[ch] = 1'b1;
         end
         checkOutput("chan_read_req", 32'(chan_read_req), 32'(expReq));
         checkOutput("readout_done", 32'(readout_done), 32'(c == doneAt));
         checkOutput("evt_ready", 32'(evt_ready), 32'(c == 0));
         if (c == 0) checkOutput("state_idle_at_accept", 32'(state), 32'd1);
         if (c == 1) begin
            checkOutput("trig_num_latched", 32'(cur_trig_num), 32'(tnum));
            checkOutput("trig_type_latched", 32'(cur_trig_type), 32'(ttype));
            checkOutput("timeout_mask_cleared", 32'(timeout_mask), 32'd0);
         end
         if (c == doneAt) begin
            checkOutput("timeout_mask_final", 32'(timeout_mask), 32'(expMask));
            checkOutput("events_read", 32'(events_read), 32'(modelCount));
            checkOutput("trig_num_hold", 32'(cur_trig_num), 32'(tnum));
            checkOutput("state_idle_after", 32'(state), 32'd1);
         end
      end
      evt_valid      = 1'b0;
      chan_read_done = '0;
   endtask

   // Accepts an event, lets the first channel enter WAIT, then resets and
   // checks that the event is abandoned with every output cleared.
   task automatic applyAbort(input logic [NCHAN-1:0] en);
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         evt_valid      = (c == 0);
         evt_data       = {5'd0, 3'd5, 24'h123456};
         chan_en        = en;
         chan_read_done = '0;
         #1;
         if (c == 3) checkOutput("abort_req_issued", 32'(chan_read_req != 0), 32'd1);
      end
      reset = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("rst_state", 32'(state), 32'd1);
      checkOutput("rst_req", 32'(chan_read_req), 32'd0);
      checkOutput("rst_done", 32'(readout_done), 32'd0);
      checkOutput("rst_tmask", 32'(timeout_mask), 32'd0);
      checkOutput("rst_trig", 32'({cur_trig_type, cur_trig_num}), 32'd0);
      checkOutput("rst_count", 32'(events_read), 32'd0);
      reset      = 1'b0;
      modelCount = 16'd0;
      for (int c = 0; c < TIMEOUT + 4; c++) begin
         @(negedge clk);
         #1;
         checkOutput("abort_no_req", 32'(chan_read_req), 32'd0);
         checkOutput("abort_no_done", 32'(readout_done), 32'd0);
      end
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      modelCount     = 16'd0;
      reset          = 1'b1;
      chan_en        = '0;
      evt_valid      = 1'b0;
      evt_data       = '0;
      chan_read_done = '0;
      levelDone      = 1'b0;
      randNoise      = 1'b0;
      holdValid      = 1'b0;
      noiseConst     = '0;
      for (int ch = 0; ch < NCHAN; ch++) dly[ch] = 10;

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("reset_state", 32'(state), 32'd1);
      checkOutput("reset_req", 32'(chan_read_req), 32'd0);
      checkOutput("reset_done", 32'(readout_done), 32'd0);
      checkOutput("reset_count", 32'(events_read), 32'd0);
      checkOutput("reset_tmask", 32'(timeout_mask), 32'd0);
      reset = 1'b0;

      $display("[TB] three channels, done 10 cycles after each request");
      applyStimulus(5'b10101, 3'd1, 24'h00ABCD);

      $display("[TB] no channels enabled");
      applyStimulus(5'b00000, 3'd2, 24'h000042);

      $display("[TB] channel 1 never answers");
      dly[0] = 2;
      dly[1] = NEVER;
      applyStimulus(5'b00011, 3'd3, 24'h0BEEF0);

      $display("[TB] stray done on ch3, ch0 done on the last timer count");
      dly[0]     = TIMEOUT - 1;
      noiseConst = 5'b01000;
      applyStimulus(5'b00001, 3'd4, 24'h777777);
      noiseConst = '0;

      $display("[TB] back-to-back words with counter wrap");
      @(negedge clk);
      force dut.events_read_d = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.events_read_d;
      modelCount = 16'hFFFF;
      checkOutput("count_preset", 32'(events_read), 32'hFFFF);
      holdValid = 1'b1;
      dly[0] = 4;
      dly[1] = 0;
      dly[2] = 7;
      applyStimulus(5'b00111, 3'd6, 24'h000001);
      applyStimulus(5'b00101, 3'd7, 24'h000002);
      holdValid = 1'b0;

      $display("[TB] reset during WAIT");
      applyAbort(5'b00110);
      for (int ch = 0; ch < NCHAN; ch++) dly[ch] = 3;
      applyStimulus(5'b11000, 3'd0, 24'hFEDCBA);

      $display("[TB] randomized events");
      randNoise = 1'b1;
      for (int n = 0; n < 40; n++) begin
         for (int ch = 0; ch < NCHAN; ch++) begin
            dly[ch] = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, TIMEOUT + 3));
         end
         levelDone = 1'($urandom);
         holdValid = 1'($urandom);
         applyStimulus(NCHAN'($urandom), 3'($urandom), 24'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
